// File: rtl/lz_normalizer.sv
// Iterative leading-zero normalizer: byte-wise left shifts in SCAN, then a final 0..7 bit
// fix-up shift, producing a normalized significand, adjusted exponent and shift count.
module lz_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] fi,
  input  logic [12:0] ei,
  input  logic        db,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] fo,
  output logic [12:0] eo,
  output logic [5:0]  lz,
  output logic        zero
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] work_q, work_d;
  logic [12:0] ei_q, ei_d;
  logic [12:0] eo_q, eo_d;
  logic [5:0]  lz_q, lz_d;
  logic        zero_q, zero_d;

  logic [63:0] fi_masked;
  logic [2:0]  p;
  logic [5:0]  lz_fin;

  // Single precision only carries significant bits in fi[63:40].
  assign fi_masked = db ? fi : {fi[63:40], 40'h0};

  // Distance from bit 63 to the leading one in the top byte; the highest set bit wins.
  always_comb begin
    p = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (work_q[56+i]) p = 3'(7 - i);
    end
  end

  assign lz_fin = lz_q + {3'b000, p};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    ei_d    = ei_q;
    eo_d    = eo_q;
    lz_d    = lz_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = fi_masked;
          ei_d    = ei;
          zero_d  = (fi_masked == 64'h0);
          lz_d    = 6'd0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (zero_q) begin
          work_d  = 64'h0;
          lz_d    = 6'd0;
          eo_d    = ei_q;
          state_d = StDone;
        end else if (work_q[63:56] == 8'h00) begin
          // Nonzero operand guarantees at most seven of these before the fix-up.
          work_d = {work_q[55:0], 8'h00};
          lz_d   = lz_q + 6'd8;
        end else begin
          work_d  = work_q << p;
          lz_d    = lz_fin;
          eo_d    = ei_q - {7'b0, lz_fin};
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= 64'h0;
      ei_q    <= 13'h0;
      eo_q    <= 13'h0;
      lz_q    <= 6'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      ei_q    <= ei_d;
      eo_q    <= eo_d;
      lz_q    <= lz_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign fo        = work_q;
  assign eo        = eo_q;
  assign lz        = lz_q;
  assign zero      = zero_q;

endmodule

// File: doc/lz_normalizer.md
LZ_NORMALIZER -- requirements
Module: lz_normalizer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand valid.
REQ-005 in_ready  output  1  operand can be accepted.
REQ-006 fi  input  64  unnormalized significand, MSB-aligned.
REQ-007 ei  input  13  exponent, two's complement.
REQ-008 db  input  1  1 = double (all 64 bits used); 0 = single (fi[39:0] masked to zero at capture).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 fo  output  64  normalized significand (fo[63]=1 unless zero).
REQ-012 eo  output  13  ei − lz, modulo 2^13.
REQ-013 lz  output  6  leading-zero count of the masked fi; feeds the rounder shift-distance input.
REQ-014 zero  output  1  masked fi was all zeros.

Function
REQ-015 States SHALL be IDLE, SCAN and DONE.
REQ-016 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-017 Accept rule: in_valid & in_ready at an edge captures masked fi, ei and zero=(masked fi==0), clears lz to 0 and moves IDLE→SCAN.
REQ-018 SCAN with zero=1: next edge → DONE with fo=0, lz=0, eo=ei.
REQ-019 SCAN with zero=0 and working reg [63:56]==0: shift left 8, lz+=8, stay in SCAN.
REQ-020 SCAN with zero=0 and [63:56]!=0: shift left by p (0..7), where p = position of the leading one below bit 63; lz+=p; → DONE.
REQ-021 Number of SCAN cycles SHALL be k = floor(lz/8)+1, at most 8; out_valid SHALL rise k cycles after the accepting edge.
REQ-022 The lz accumulator SHALL never exceed 63, because nonzero input guarantees termination.
REQ-023 eo SHALL equal ei − lz, computed in 13 bits, wrapping with no saturation or flag.
REQ-024 DONE: outputs SHALL be held stable while out_ready=0.
REQ-025 out_valid & out_ready → IDLE; there is no same-cycle re-accept, since in_ready is 0 in DONE.
REQ-026 in_valid in SCAN or DONE SHALL be ignored; inputs are sampled only at the accepting edge.
REQ-027 fo, eo, lz and zero SHALL be registered, with no combinational path from fi, ei, db or out_ready.
REQ-028 A db change after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-029 rst_n=0 SHALL force, asynchronously, state=IDLE, in_ready=1, out_valid=0, fo=0, eo=0, lz=0, zero=0.
REQ-030 Reset asserted in SCAN or DONE SHALL abort the operation with no result emitted; the first edge after deassertion can accept a new operand.

Verification
REQ-031 fi=0x8000_0000_0000_0000, db=1, ei=0x0400 -> k=1, fo=0x8000_0000_0000_0000, lz=0, eo=0x0400, zero=0.
REQ-032 fi=0x0000_0000_0000_0001, db=1, ei=0x0000 -> k=8, fo=0x8000_0000_0000_0000, lz=63, eo=0x1FC1.
REQ-033 Two db=0 cases:
  - fi=0x0000_0000_FFFF_FFFF -> masked to 0, zero=1, fo=0, lz=0, eo=ei, k=1.
  - fi=0x0000_0100_0000_0000, ei=0x0010 -> lz=23, fo=0x8000_0000_0000_0000, eo=0x1FF9, k=3.
REQ-034 Result in DONE, out_ready held 0 for 5 cycles, in_valid=1 with a new operand -> fo/eo/lz/zero unchanged, in_ready=0; out_ready=1 -> IDLE next edge, then the new operand is accepted.
REQ-035 fi=0x0000_0000_0000_00F0, then rst_n pulsed low in the 3rd SCAN cycle -> out_valid=0 and in_ready=1 immediately; a following fi=0x4000_0000_0000_0000 -> lz=1, fo=0x8000_0000_0000_0000, k=1.
